// File: rtl/barrel_shift_pkg.sv
// Shared constants for the iterative barrel-shift normalizer.
//   WIDTH / SHW  : default data width and shift-count width
//   ST_*         : FSM state encoding
//   DIR_*        : normalization direction encoding for in_dir
package barrel_shift_pkg;

    localparam int WIDTH = 8;
    localparam int SHW   = $clog2(WIDTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/barrel_shift_normalizer_step.sv
// One normalization step: single-bit logical shift toward the target end
// plus a test of whether the target bit is already set.
//   data      in   WIDTH  current word
//   dir       in   1      DIR_LEFT: target is MSB; DIR_RIGHT: target is LSB
//   next_data out  WIDTH  word shifted one bit toward the target, zero filled
//   hit       out  1      target bit of data is 1
module normalizer_step
    import barrel_shift_pkg::*;
#(
    parameter int WIDTH = barrel_shift_pkg::WIDTH
) (
    input  logic [WIDTH-1:0] data,
    input  logic             dir,
    output logic [WIDTH-1:0] next_data,
    output logic             hit
);

    always_comb begin
        if (dir == DIR_RIGHT) begin
            next_data = data >> 1;
            hit       = data[0];
        end else begin
            next_data = data << 1;
            hit       = data[WIDTH-1];
        end
    end

endmodule

// File: rtl/barrel_shift_normalizer.sv
// Iterative normalizer: shifts a word one bit per cycle until the target end
// bit is 1, then reports the normalized word and the number of shifts, so the
// original alignment can be restored by shifting back by out_shift.
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous active-high reset
//   in_valid   in   1      producer has a word
//   in_ready   out  1      block can accept (IDLE and not in reset)
//   in_data    in   WIDTH  word to normalize
//   in_dir     in   1      0: toward MSB (shift left); 1: toward LSB (shift right)
//   out_valid  out  1      result valid (DONE)
//   out_ready  in   1      consumer accepts the result
//   out_data   out  WIDTH  normalized word
//   out_shift  out  SHW    number of single-bit shifts applied
//   out_zero   out  1      input was all zeros
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for a word; in_ready high
// ST_SHIFT | one shift (or termination test) per cycle
// ST_DONE  | result presented; held until out_ready
module barrel_shift_normalizer
    import barrel_shift_pkg::*;
#(
    parameter int WIDTH = barrel_shift_pkg::WIDTH,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_dir,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [SHW-1:0]   out_shift,
    output logic             out_zero
);

    logic [1:0]       state;
    logic [WIDTH-1:0] data_r;
    logic             dir_r;
    logic [SHW-1:0]   cnt_r;
    logic [WIDTH-1:0] next_data;
    logic             hit;

    normalizer_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .data      (data_r),
        .dir       (dir_r),
        .next_data (next_data),
        .hit       (hit)
    );

    assign in_ready  = (state == ST_IDLE) && !rst;
    assign out_valid = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            data_r    <= '0;
            dir_r     <= DIR_LEFT;
            cnt_r     <= '0;
            out_data  <= '0;
            out_shift <= '0;
            out_zero  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        data_r <= in_data;
                        dir_r  <= in_dir;
                        cnt_r  <= '0;
                        state  <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (data_r == '0) begin
                        out_zero  <= 1'b1;
                        out_shift <= '0;
                        out_data  <= '0;
                        state     <= ST_DONE;
                    end else if (hit) begin
                        out_zero  <= 1'b0;
                        out_shift <= cnt_r;
                        out_data  <= data_r;
                        state     <= ST_DONE;
                    end else begin
                        // A nonzero word hits its target within WIDTH-1 shifts,
                        // so the count cannot wrap.
                        data_r <= next_data;
                        cnt_r  <= cnt_r + SHW'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_barrel_shift_normalizer.sv
module tb_barrel_shift_normalizer;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_dir;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [2:0] out_shift;
    logic       out_zero;

    int checks = 0;
    int errors = 0;

    barrel_shift_normalizer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_dir    (in_dir),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_shift (out_shift),
        .out_zero  (out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       dir;
        logic [7:0] data;
        logic [7:0] exp_data;
        logic [2:0] exp_shift;
        logic       exp_zero;
        logic [3:0] exp_lat;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: locate the set bit nearest the target end and move it there
    // in one step; the distance is the shift count.
    function automatic void model(input logic dir, input logic [7:0] d,
                                  output logic [7:0] od, output logic [2:0] os,
                                  output logic oz);
        int k;
        od = 8'h00;
        os = 3'd0;
        oz = (d == 8'h00);
        if (!oz) begin
            k = 0;
            if (dir == 1'b0) begin
                for (int p = 7; p >= 0; p--) if (d[p]) begin k = 7 - p; break; end
                od = d << k;
            end else begin
                for (int p = 0; p <= 7; p++) if (d[p]) begin k = p; break; end
                od = d >> k;
            end
            os = 3'(k);
        end
    endfunction

    // Runs one job; keeps the result in DONE for 'hold' cycles of backpressure
    // while pulsing in_valid, then releases it.
    task automatic run_job(input logic dir, input logic [7:0] d, input int hold,
                           output logic [7:0] gd, output logic [2:0] gs,
                           output logic gz, output int lat);
        int wait_cnt;
        gd = 8'h00; gs = 3'd0; gz = 1'b0; lat = 0;
        @(negedge clk);
        wait_cnt = 0;
        while (!in_ready && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", 32'(in_ready), 32'd1);
            return;
        end
        in_valid = 1'b1;
        in_data  = d;
        in_dir   = dir;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = ~d;
        in_dir   = ~dir;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid) break;
            // Busy: new words must be refused.
            if (in_ready) chk("in_ready_busy", 32'(in_ready), 32'd0);
        end
        if (!out_valid) begin
            chk("out_valid_timeout", 32'(out_valid), 32'd1);
            return;
        end
        gd = out_data;
        gs = out_shift;
        gz = out_zero;
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            in_data  = 8'(h * 37 + 5);
            in_dir   = h[0];
            @(negedge clk);
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_ready", 32'(in_ready), 32'd0);
            chk("hold_data", 32'(out_data), 32'(gd));
            chk("hold_shift", 32'(out_shift), 32'(gs));
            chk("hold_zero", 32'(out_zero), 32'(gz));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("release_valid", 32'(out_valid), 32'd0);
        chk("release_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [7:0] gd, md, restored;
        logic [2:0] gs, ms;
        logic       gz, mz, rdir;
        int         lat;

        vecs[0] = '{dir:1'b0, data:8'b10110001, exp_data:8'b10110001, exp_shift:3'd0, exp_zero:1'b0, exp_lat:4'd1};
        vecs[1] = '{dir:1'b0, data:8'b00010110, exp_data:8'b10110000, exp_shift:3'd3, exp_zero:1'b0, exp_lat:4'd4};
        vecs[2] = '{dir:1'b1, data:8'b10110000, exp_data:8'b00001011, exp_shift:3'd4, exp_zero:1'b0, exp_lat:4'd5};
        vecs[3] = '{dir:1'b0, data:8'h00,       exp_data:8'h00,       exp_shift:3'd0, exp_zero:1'b1, exp_lat:4'd1};
        vecs[4] = '{dir:1'b1, data:8'h00,       exp_data:8'h00,       exp_shift:3'd0, exp_zero:1'b1, exp_lat:4'd1};
        vecs[5] = '{dir:1'b0, data:8'h01,       exp_data:8'h80,       exp_shift:3'd7, exp_zero:1'b0, exp_lat:4'd8};
        vecs[6] = '{dir:1'b1, data:8'h80,       exp_data:8'h01,       exp_shift:3'd7, exp_zero:1'b0, exp_lat:4'd8};
        vecs[7] = '{dir:1'b1, data:8'h01,       exp_data:8'h01,       exp_shift:3'd0, exp_zero:1'b0, exp_lat:4'd1};

        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_dir = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_shift", 32'(out_shift), 32'd0);
        chk("rst_out_zero", 32'(out_zero), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 8; i++) begin
            run_job(vecs[i].dir, vecs[i].data, 0, gd, gs, gz, lat);
            chk($sformatf("vec%0d_data", i), 32'(gd), 32'(vecs[i].exp_data));
            chk($sformatf("vec%0d_shift", i), 32'(gs), 32'(vecs[i].exp_shift));
            chk($sformatf("vec%0d_zero", i), 32'(gz), 32'(vecs[i].exp_zero));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
        end

        // Round trip of the right-normalized 8'b10110000.
        run_job(1'b1, 8'b10110000, 0, gd, gs, gz, lat);
        restored = gd << gs;
        chk("roundtrip_b0", 32'(restored), 32'hB0);

        // Backpressure: 5 held cycles with in_valid pulses, then 8'h40 left -> shift 1.
        run_job(1'b0, 8'h10, 5, gd, gs, gz, lat);
        chk("bp_data", 32'(gd), 32'h80);
        chk("bp_shift", 32'(gs), 32'd3);
        run_job(1'b0, 8'h40, 0, gd, gs, gz, lat);
        chk("after_bp_data", 32'(gd), 32'h80);
        chk("after_bp_shift", 32'(gs), 32'd1);
        chk("after_bp_latency", 32'(lat), 32'd2);

        // Reset during SHIFT of 8'h02 (left needs 6 shifts).
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'h02; in_dir = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("pre_rst_busy", 32'(in_ready), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_data", 32'(out_data), 32'd0);
        chk("midrst_out_shift", 32'(out_shift), 32'd0);
        chk("midrst_out_zero", 32'(out_zero), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        run_job(1'b1, 8'h02, 0, gd, gs, gz, lat);
        chk("after_rst_data", 32'(gd), 32'h01);
        chk("after_rst_shift", 32'(gs), 32'd1);
        chk("after_rst_zero", 32'(gz), 32'd0);

        // Randomized jobs against the reference model.
        for (int n = 0; n < 40; n++) begin
            logic [7:0] rd;
            rdir = 1'($urandom);
            rd   = 8'($urandom);
            if (n % 3 == 0) rd = rd & 8'($urandom) & 8'($urandom);
            if (n % 11 == 0) rd = 8'h00;
            model(rdir, rd, md, ms, mz);
            run_job(rdir, rd, n % 4, gd, gs, gz, lat);
            chk($sformatf("rnd%0d_data", n), 32'(gd), 32'(md));
            chk($sformatf("rnd%0d_shift", n), 32'(gs), 32'(ms));
            chk($sformatf("rnd%0d_zero", n), 32'(gz), 32'(mz));
            chk($sformatf("rnd%0d_latency", n), 32'(lat), 32'(ms) + 32'd1);
            if (!mz) begin
                restored = rdir ? (gd << gs) : (gd >> gs);
                chk($sformatf("rnd%0d_roundtrip", n), 32'(restored), 32'(rd));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
